// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, default fetch vectors and the
// next-PC select encoding used by the fetch stage.
package cpu_pkg;

  localparam logic [31:0] NOP_INS         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_INT_VEC  = 32'h0000_0100;

  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_HOLD,
    NPC_REDIR,
    NPC_ERET,
    NPC_INT
  } npc_sel_t;

endpackage

// File: rtl/if_stage_next_pc_mux.sv
// Next-PC priority encoder and mux for the fetch stage (purely combinational).
module next_pc_mux
  import cpu_pkg::*;
#(
  parameter logic [31:0] INT_VEC = DEFAULT_INT_VEC
) (
  input  logic        halted,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic        halt,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        irq,
  input  logic        int_en,
  input  logic [31:0] pc,
  output npc_sel_t    sel,
  output logic [31:0] npc
);

  // Redirect outranks stall so a branch resolved in EX squashes a held ID instruction.
  always_comb begin
    sel = NPC_SEQ;
    if (halted)              sel = NPC_HOLD;
    else if (redirect)       sel = NPC_REDIR;
    else if (stall || halt)  sel = NPC_HOLD;
    else if (eret)           sel = NPC_ERET;
    else if (irq && int_en)  sel = NPC_INT;
  end

  always_comb begin
    npc = pc + 32'd1;
    case (sel)
      NPC_HOLD:  npc = pc;
      NPC_REDIR: npc = redirect_pc;
      NPC_ERET:  npc = epc;
      NPC_INT:   npc = INT_VEC;
      default:   npc = pc + 32'd1;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register, interrupt entry, eret return,
// sticky halt and cycle/flush counters.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] INT_VEC  = DEFAULT_INT_VEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        irq,
  input  logic        int_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ins,
  output logic [31:0] pc_id,
  output logic        valid_id,
  output logic        int_ack,
  output logic [31:0] epc_save,
  output logic [31:0] cyc_cnt,
  output logic [31:0] flush_cnt
);

  logic [31:0] r_pc_p0;
  logic [31:0] r_ins_p1;
  logic [31:0] r_pc_p1;
  logic        r_vld_p1;
  logic        r_halted;
  logic        r_int_ack;
  logic [31:0] r_epc_save;
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_flush_cnt;
  npc_sel_t    w_sel;
  logic [31:0] w_npc;

  next_pc_mux #(.INT_VEC(INT_VEC)) u_next_pc_mux (
    .halted      (r_halted),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .halt        (halt),
    .eret        (eret),
    .epc         (epc),
    .irq         (irq),
    .int_en      (int_en),
    .pc          (r_pc_p0),
    .sel         (w_sel),
    .npc         (w_npc)
  );

  // p0 -> p1: PC update and IF/ID load, flush or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_p0     <= RESET_PC;
      r_ins_p1    <= NOP_INS;
      r_pc_p1     <= 32'd0;
      r_vld_p1    <= 1'b0;
      r_halted    <= 1'b0;
      r_int_ack   <= 1'b0;
      r_epc_save  <= 32'd0;
      r_cyc_cnt   <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_pc_p0   <= w_npc;
      r_int_ack <= 1'b0;
      if (!r_halted) r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (r_halted) begin
        r_ins_p1 <= NOP_INS;
        r_pc_p1  <= 32'd0;
        r_vld_p1 <= 1'b0;
      end else begin
        case (w_sel)
          NPC_SEQ: begin
            r_ins_p1 <= imem_data;
            r_pc_p1  <= r_pc_p0;
            r_vld_p1 <= 1'b1;
          end
          NPC_HOLD: begin
            // Stall keeps IF/ID intact; only a halt request lands here without stall.
            if (!stall) begin
              r_halted <= 1'b1;
              r_ins_p1 <= NOP_INS;
              r_pc_p1  <= 32'd0;
              r_vld_p1 <= 1'b0;
            end
          end
          NPC_REDIR, NPC_ERET, NPC_INT: begin
            r_ins_p1    <= NOP_INS;
            r_pc_p1     <= 32'd0;
            r_vld_p1    <= 1'b0;
            r_flush_cnt <= r_flush_cnt + 32'd1;
            if (w_sel == NPC_INT) begin
              r_int_ack  <= 1'b1;
              r_epc_save <= r_pc_p0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_addr = r_pc_p0;
  assign ins       = r_ins_p1;
  assign pc_id     = r_pc_p1;
  assign valid_id  = r_vld_p1;
  assign int_ack   = r_int_ack;
  assign epc_save  = r_epc_save;
  assign cyc_cnt   = r_cyc_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
